// File: rtl/fe_bp_pkg.sv
// Shared types and constants for the gshare fetch stage and its predictor tables.
package fe_bp_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } fe_state_e;

  typedef logic [1:0] pt_ctr_t;

  // BTB fields are sized for the widest supported PC; narrower builds use the low bits.
  localparam int unsigned BTB_FIELD_BITS = 32;

  typedef struct packed {
    logic                      valid;
    logic [BTB_FIELD_BITS-1:0] tag;
    logic [BTB_FIELD_BITS-1:0] target;
  } btb_entry_t;

  localparam pt_ctr_t     CTR_MAX  = 2'd3;
  localparam int unsigned INSTSIZE = 4;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic pt_ctr_t ctr_step(input pt_ctr_t c, input logic taken);
    if (taken) return (c == CTR_MAX) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/fe_bp_tables.sv
// Gshare storage: pattern table, tagged BTB and BHR, with init walker, update port and comb lookup.
module fe_bp_tables
  import fe_bp_pkg::*;
#(
  parameter int unsigned DBITS        = 32,
  parameter int unsigned PT_IDX_BITS  = 8,
  parameter int unsigned BTB_IDX_BITS = 4,
  parameter int unsigned INIT_BITS    = 8,
  parameter pt_ctr_t     PT_INIT      = 2'b01
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_en,
  input  logic [INIT_BITS-1:0]    init_ptr,
  input  logic                    upd_en,
  input  logic                    upd_is_branch,
  input  logic                    upd_taken,
  input  logic [DBITS-1:0]        upd_pc,
  input  logic [DBITS-1:0]        upd_target,
  input  logic [PT_IDX_BITS-1:0]  upd_pt_idx,
  input  logic [DBITS-1:0]        lk_pc,
  output logic                    lk_hit_c,
  output logic                    lk_pred_taken_c,
  output logic [DBITS-1:0]        lk_pred_tgt_c,
  output logic [PT_IDX_BITS-1:0]  lk_pt_idx_c
);

  localparam int unsigned PT_ENTRIES  = 1 << PT_IDX_BITS;
  localparam int unsigned BTB_ENTRIES = 1 << BTB_IDX_BITS;

  pt_ctr_t    pt_mem  [PT_ENTRIES];
  btb_entry_t btb_mem [BTB_ENTRIES];
  logic [PT_IDX_BITS-1:0] bhr;

  logic [BTB_IDX_BITS-1:0] upd_btb_idx_c, lk_btb_idx_c;
  logic                    pt_in_range_c, btb_in_range_c;
  btb_entry_t              lk_entry_c;
  logic                    unused_pc_bits_c;

  assign upd_btb_idx_c    = upd_pc[BTB_IDX_BITS+1:2];
  assign pt_in_range_c    = (init_ptr >> PT_IDX_BITS) == '0;
  assign btb_in_range_c   = (init_ptr >> BTB_IDX_BITS) == '0;
  assign unused_pc_bits_c = ^upd_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) bhr <= '0;
    else if (upd_en && upd_is_branch) bhr <= {bhr[PT_IDX_BITS-2:0], upd_taken};
  end

  // Init walker has priority; the top never asserts both.
  always_ff @(posedge clk) begin
    if (init_en) begin
      if (pt_in_range_c)  pt_mem[PT_IDX_BITS'(init_ptr)] <= PT_INIT;
      if (btb_in_range_c) btb_mem[BTB_IDX_BITS'(init_ptr)].valid <= 1'b0;
    end else if (upd_en) begin
      if (upd_is_branch) pt_mem[upd_pt_idx] <= ctr_step(pt_mem[upd_pt_idx], upd_taken);
      if (!upd_is_branch || upd_taken)
        btb_mem[upd_btb_idx_c] <= '{valid:  1'b1,
                                    tag:    BTB_FIELD_BITS'(upd_pc[DBITS-1:BTB_IDX_BITS+2]),
                                    target: BTB_FIELD_BITS'(upd_target)};
    end
  end

  // Lookup reads pre-update state; no write bypass.
  assign lk_pt_idx_c     = lk_pc[PT_IDX_BITS+1:2] ^ bhr;
  assign lk_btb_idx_c    = lk_pc[BTB_IDX_BITS+1:2];
  assign lk_entry_c      = btb_mem[lk_btb_idx_c];
  assign lk_hit_c        = lk_entry_c.valid &&
                           (lk_entry_c.tag == BTB_FIELD_BITS'(lk_pc[DBITS-1:BTB_IDX_BITS+2]));
  assign lk_pred_taken_c = lk_hit_c && pt_mem[lk_pt_idx_c][1];
  assign lk_pred_tgt_c   = lk_pred_taken_c ? lk_entry_c.target[DBITS-1:0]
                                           : lk_pc + DBITS'(INSTSIZE);

endmodule

// File: rtl/fe_gshare_stage.sv
// Fetch stage: PC register, INIT/RUN FSM, FE latch and debug counters around fe_bp_tables.
// Optional FE_PERF_CNT_EN adds fetch/taken/redirect performance counters.
module fe_gshare_stage
  import fe_bp_pkg::*;
#(
  parameter int unsigned      DBITS        = 32,
  parameter int unsigned      INSTBITS     = 32,
  parameter logic [DBITS-1:0] STARTPC      = DBITS'(32'h100),
  parameter int unsigned      PT_IDX_BITS  = 8,
  parameter int unsigned      BTB_IDX_BITS = 4,
  parameter pt_ctr_t          PT_INIT      = 2'b01
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  output logic [DBITS-1:0]       imem_addr_o,
  input  logic [INSTBITS-1:0]    imem_rdata_i,
  input  logic                   redir_valid_i,
  input  logic [DBITS-1:0]       redir_pc_i,
  input  logic                   upd_valid_i,
  input  logic                   upd_is_branch_i,
  input  logic                   upd_taken_i,
  input  logic [DBITS-1:0]       upd_pc_i,
  input  logic [DBITS-1:0]       upd_target_i,
  input  logic [PT_IDX_BITS-1:0] upd_pt_idx_i,
  output logic                   init_busy_o,
  output logic                   fe_valid_o,
  output logic [INSTBITS-1:0]    fe_inst_o,
  output logic [DBITS-1:0]       fe_pc_o,
  output logic [DBITS-1:0]       fe_pcplus_o,
  output logic                   fe_btb_hit_o,
  output logic                   fe_pred_taken_o,
  output logic [DBITS-1:0]       fe_pred_tgt_o,
  output logic [PT_IDX_BITS-1:0] fe_pt_idx_o,
  output logic [DBITS-1:0]       fe_inst_cnt_o
`ifdef FE_PERF_CNT_EN
  ,
  output logic [DBITS-1:0]       perf_fetch_o,
  output logic [DBITS-1:0]       perf_taken_o,
  output logic [DBITS-1:0]       perf_redir_o
`endif
);

  localparam int unsigned INIT_BITS = (PT_IDX_BITS > BTB_IDX_BITS) ? PT_IDX_BITS : BTB_IDX_BITS;
  localparam logic [INIT_BITS-1:0] INIT_LAST = '1;

  fe_state_e              state_q, state_n;
  logic [INIT_BITS-1:0]   init_ptr_q, init_ptr_n;
  logic [DBITS-1:0]       pc_q, pc_n, cnt_n;
  logic                   fe_valid_n, fe_btb_hit_n, fe_pred_taken_n;
  logic [INSTBITS-1:0]    fe_inst_n;
  logic [DBITS-1:0]       fe_pc_n, fe_pcplus_n, fe_pred_tgt_n;
  logic [PT_IDX_BITS-1:0] fe_pt_idx_n;
`ifdef FE_PERF_CNT_EN
  logic [DBITS-1:0]       perf_fetch_n, perf_taken_n, perf_redir_n;
`endif

  logic                   lk_hit_c, lk_pred_taken_c;
  logic [DBITS-1:0]       lk_pred_tgt_c;
  logic [PT_IDX_BITS-1:0] lk_pt_idx_c;

  assign imem_addr_o = pc_q;
  assign init_busy_o = (state_q == INIT);

  fe_bp_tables #(
    .DBITS        (DBITS),
    .PT_IDX_BITS  (PT_IDX_BITS),
    .BTB_IDX_BITS (BTB_IDX_BITS),
    .INIT_BITS    (INIT_BITS),
    .PT_INIT      (PT_INIT)
  ) u_tables (
    .clk             (clk),
    .reset           (reset),
    .init_en         (state_q == INIT),
    .init_ptr        (init_ptr_q),
    .upd_en          ((state_q == RUN) && upd_valid_i),
    .upd_is_branch   (upd_is_branch_i),
    .upd_taken       (upd_taken_i),
    .upd_pc          (upd_pc_i),
    .upd_target      (upd_target_i),
    .upd_pt_idx      (upd_pt_idx_i),
    .lk_pc           (pc_q),
    .lk_hit_c        (lk_hit_c),
    .lk_pred_taken_c (lk_pred_taken_c),
    .lk_pred_tgt_c   (lk_pred_tgt_c),
    .lk_pt_idx_c     (lk_pt_idx_c)
  );

  // Next-state: redirect beats stall beats predicted next PC.
  always_comb begin
    state_n         = state_q;
    init_ptr_n      = init_ptr_q;
    pc_n            = pc_q;
    cnt_n           = fe_inst_cnt_o;
    fe_valid_n      = fe_valid_o;
    fe_inst_n       = fe_inst_o;
    fe_pc_n         = fe_pc_o;
    fe_pcplus_n     = fe_pcplus_o;
    fe_btb_hit_n    = fe_btb_hit_o;
    fe_pred_taken_n = fe_pred_taken_o;
    fe_pred_tgt_n   = fe_pred_tgt_o;
    fe_pt_idx_n     = fe_pt_idx_o;
`ifdef FE_PERF_CNT_EN
    perf_fetch_n    = perf_fetch_o;
    perf_taken_n    = perf_taken_o;
    perf_redir_n    = perf_redir_o;
`endif
    case (state_q)
      INIT: begin
        init_ptr_n = init_ptr_q + INIT_BITS'(1);
        if (init_ptr_q == INIT_LAST) state_n = RUN;
      end
      RUN: begin
        if (redir_valid_i) begin
          pc_n       = redir_pc_i;
          fe_valid_n = 1'b0;
          cnt_n      = fe_inst_cnt_o + DBITS'(1);
`ifdef FE_PERF_CNT_EN
          perf_redir_n = perf_redir_o + DBITS'(1);
`endif
        end else if (!stall_i) begin
          pc_n            = lk_pred_tgt_c;
          fe_valid_n      = 1'b1;
          fe_inst_n       = imem_rdata_i;
          fe_pc_n         = pc_q;
          fe_pcplus_n     = pc_q + DBITS'(INSTSIZE);
          fe_btb_hit_n    = lk_hit_c;
          fe_pred_taken_n = lk_pred_taken_c;
          fe_pred_tgt_n   = lk_pred_tgt_c;
          fe_pt_idx_n     = lk_pt_idx_c;
          cnt_n           = fe_inst_cnt_o + DBITS'(1);
`ifdef FE_PERF_CNT_EN
          perf_fetch_n = perf_fetch_o + DBITS'(1);
          if (lk_pred_taken_c) perf_taken_n = perf_taken_o + DBITS'(1);
`endif
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= INIT;
      init_ptr_q      <= '0;
      pc_q            <= STARTPC;
      fe_inst_cnt_o   <= DBITS'(1);
      fe_valid_o      <= 1'b0;
      fe_inst_o       <= '0;
      fe_pc_o         <= '0;
      fe_pcplus_o     <= '0;
      fe_btb_hit_o    <= 1'b0;
      fe_pred_taken_o <= 1'b0;
      fe_pred_tgt_o   <= '0;
      fe_pt_idx_o     <= '0;
`ifdef FE_PERF_CNT_EN
      perf_fetch_o    <= '0;
      perf_taken_o    <= '0;
      perf_redir_o    <= '0;
`endif
    end else begin
      state_q         <= state_n;
      init_ptr_q      <= init_ptr_n;
      pc_q            <= pc_n;
      fe_inst_cnt_o   <= cnt_n;
      fe_valid_o      <= fe_valid_n;
      fe_inst_o       <= fe_inst_n;
      fe_pc_o         <= fe_pc_n;
      fe_pcplus_o     <= fe_pcplus_n;
      fe_btb_hit_o    <= fe_btb_hit_n;
      fe_pred_taken_o <= fe_pred_taken_n;
      fe_pred_tgt_o   <= fe_pred_tgt_n;
      fe_pt_idx_o     <= fe_pt_idx_n;
`ifdef FE_PERF_CNT_EN
      perf_fetch_o    <= perf_fetch_n;
      perf_taken_o    <= perf_taken_n;
      perf_redir_o    <= perf_redir_n;
`endif
    end
  end

endmodule

// File: tb/tb_fe_gshare_stage.sv
// Directed scoreboard bench for fe_gshare_stage (default parameters).
module tb_fe_gshare_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, upd_valid, upd_is_branch, upd_taken;
  logic [31:0] imem_addr, imem_rdata, redir_pc, upd_pc, upd_target;
  logic [7:0]  upd_pt_idx, fe_pt_idx;
  logic        init_busy, fe_valid, fe_btb_hit, fe_pred_taken;
  logic [31:0] fe_inst, fe_pc, fe_pcplus, fe_pred_tgt, fe_inst_cnt;
`ifdef FE_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_taken, perf_redir;
`endif

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  fe_gshare_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall),
    .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .redir_valid_i(redir_valid), .redir_pc_i(redir_pc),
    .upd_valid_i(upd_valid), .upd_is_branch_i(upd_is_branch), .upd_taken_i(upd_taken),
    .upd_pc_i(upd_pc), .upd_target_i(upd_target), .upd_pt_idx_i(upd_pt_idx),
    .init_busy_o(init_busy), .fe_valid_o(fe_valid), .fe_inst_o(fe_inst),
    .fe_pc_o(fe_pc), .fe_pcplus_o(fe_pcplus), .fe_btb_hit_o(fe_btb_hit),
    .fe_pred_taken_o(fe_pred_taken), .fe_pred_tgt_o(fe_pred_tgt),
    .fe_pt_idx_o(fe_pt_idx), .fe_inst_cnt_o(fe_inst_cnt)
`ifdef FE_PERF_CNT_EN
    , .perf_fetch_o(perf_fetch), .perf_taken_o(perf_taken), .perf_redir_o(perf_redir)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [7:0]  idx;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  bhr_m = '0;
  int          cnt_m = 1;
  logic        upd_pend = 1'b0;
  int          n_busy, n_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; retire a pending update into the BHR model after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (upd_pend) begin
      if (upd_is_branch) bhr_m = {bhr_m[6:0], upd_taken};
      upd_valid = 1'b0;
      upd_pend  = 1'b0;
    end
  endtask

  task automatic upd(input logic br, input logic tk, input logic [31:0] pc,
                     input logic [31:0] tgt, input logic [7:0] idx);
    upd_valid = 1'b1; upd_is_branch = br; upd_taken = tk;
    upd_pc = pc; upd_target = tgt; upd_pt_idx = idx;
    upd_pend = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic hit, input logic tk,
                       input logic [31:0] tgt);
    exp_t e;
    sb.push_back('{pc: pc, hit: hit, taken: tk, tgt: tgt, idx: pc[9:2] ^ bhr_m});
    stall = 1'b0; redir_valid = 1'b0;
    cnt_m++;
    tick();
    e = sb.pop_front();
    chk("fe_valid", 32'(fe_valid), 32'd1);
    chk("fe_pc", fe_pc, e.pc);
    chk("fe_inst", fe_inst, e.pc ^ 32'hDEAD_0000);
    chk("fe_pcplus", fe_pcplus, e.pc + 32'd4);
    chk("fe_btb_hit", 32'(fe_btb_hit), 32'(e.hit));
    chk("fe_pred_taken", 32'(fe_pred_taken), 32'(e.taken));
    chk("fe_pred_tgt", fe_pred_tgt, e.tgt);
    chk("fe_pt_idx", 32'(fe_pt_idx), 32'(e.idx));
    chk("next_pc", imem_addr, e.tgt);
  endtask

  task automatic redir(input logic [31:0] pc);
    redir_valid = 1'b1; redir_pc = pc;
    cnt_m++;
    tick();
    redir_valid = 1'b0;
    chk("redir_bubble", 32'(fe_valid), 32'd0);
    chk("redir_pc", imem_addr, pc);
  endtask

  task automatic wait_init(output int nb, output int nv);
    nb = 0; nv = 0;
    while (init_busy && nb < 1000) begin
      nb++;
      if (fe_valid) nv++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    upd_valid = 1'b0; upd_is_branch = 1'b0; upd_taken = 1'b0;
    upd_pc = '0; upd_target = '0; upd_pt_idx = '0;

    // Reset and init walk
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_valid", 32'(fe_valid), 32'd0);
    chk("rst_fe_pc", fe_pc, 32'd0);
    chk("rst_pc", imem_addr, 32'h100);
    chk("rst_cnt", fe_inst_cnt, 32'd1);
    wait_init(n_busy, n_valid);
    chk("init_cycles", 32'(n_busy), 32'd256);
    chk("init_no_valid", 32'(n_valid), 32'd0);
    chk("run_start_pc", imem_addr, 32'h100);

    fetch(32'h100, 1'b0, 1'b0, 32'h104);
    fetch(32'h104, 1'b0, 1'b0, 32'h108);
    fetch(32'h108, 1'b0, 1'b0, 32'h10C);
    fetch(32'h10C, 1'b0, 1'b0, 32'h110);
    chk("cnt_seq", fe_inst_cnt, 32'(cnt_m));

    // Stall holds everything, then redirect wins over stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_fe_pc", fe_pc, 32'h10C);
      chk("stall_valid", 32'(fe_valid), 32'd1);
      chk("stall_pc", imem_addr, 32'h110);
      chk("stall_cnt", fe_inst_cnt, 32'(cnt_m));
    end
    redir(32'h300);
    stall = 1'b0;
    chk("cnt_redir", fe_inst_cnt, 32'(cnt_m));
    fetch(32'h300, 1'b0, 1'b0, 32'h304);

    // Train a taken branch at 0x120; updates overlap lookups (no bypass)
    upd(1'b1, 1'b1, 32'h120, 32'h200, 8'h4F); fetch(32'h304, 1'b0, 1'b0, 32'h308);
    upd(1'b1, 1'b1, 32'h120, 32'h200, 8'h4F); fetch(32'h308, 1'b0, 1'b0, 32'h30C);
    upd(1'b1, 1'b1, 32'h120, 32'h200, 8'h4F); fetch(32'h30C, 1'b0, 1'b0, 32'h310);
    redir(32'h120);
    fetch(32'h120, 1'b1, 1'b1, 32'h200);
    fetch(32'h200, 1'b0, 1'b0, 32'h204);

    // Saturation: one not-taken after saturating leaves counter at 2 (still taken)
    upd(1'b1, 1'b0, 32'h1CC, 32'h999, 8'h4F); fetch(32'h204, 1'b0, 1'b0, 32'h208);
    upd(1'b0, 1'b1, 32'h104, 32'h500, 8'h00);
    redir(32'h104);
    fetch(32'h104, 1'b1, 1'b1, 32'h500);
    fetch(32'h500, 1'b0, 1'b0, 32'h504);

    // Jump trains BTB only; weak PT counter means no taken prediction
    upd(1'b0, 1'b1, 32'h140, 32'h400, 8'h00); fetch(32'h504, 1'b0, 1'b0, 32'h508);
    redir(32'h140);
    fetch(32'h140, 1'b1, 1'b0, 32'h144);
    redir(32'h1CC);
    fetch(32'h1CC, 1'b0, 1'b0, 32'h1D0);
    chk("cnt_mid", fe_inst_cnt, 32'(cnt_m));

    // Reset mid-init restarts the walk; redirects/updates ignored while busy
    reset = 1'b1; tick(); reset = 1'b0;
    n_valid = 0; n_busy = 0;
    for (int i = 0; i < 100; i++) begin
      if (fe_valid) n_valid++;
      if (init_busy) n_busy++;
      tick();
    end
    chk("init1_busy", 32'(n_busy), 32'd100);
    chk("init1_no_valid", 32'(n_valid), 32'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    bhr_m = '0; cnt_m = 1;
    redir_valid = 1'b1; redir_pc = 32'h777;
    upd_valid = 1'b1; upd_is_branch = 1'b0; upd_taken = 1'b1;
    upd_pc = 32'h120; upd_target = 32'h888;
    wait_init(n_busy, n_valid);
    redir_valid = 1'b0; upd_valid = 1'b0;
    chk("init2_cycles", 32'(n_busy), 32'd256);
    chk("init2_no_valid", 32'(n_valid), 32'd0);
    chk("init2_pc_held", imem_addr, 32'h100);
    chk("init2_cnt", fe_inst_cnt, 32'd1);

    fetch(32'h100, 1'b0, 1'b0, 32'h104);
    fetch(32'h104, 1'b0, 1'b0, 32'h108);
    fetch(32'h108, 1'b0, 1'b0, 32'h10C);
    fetch(32'h10C, 1'b0, 1'b0, 32'h110);
    redir(32'h120);
    fetch(32'h120, 1'b0, 1'b0, 32'h124);
    fetch(32'h124, 1'b0, 1'b0, 32'h128);
    fetch(32'h128, 1'b0, 1'b0, 32'h12C);
    redir(32'h100);
    fetch(32'h100, 1'b0, 1'b0, 32'h104);
    fetch(32'h104, 1'b0, 1'b0, 32'h108);
    fetch(32'h108, 1'b0, 1'b0, 32'h10C);
    chk("cnt_end", fe_inst_cnt, 32'd13);
`ifdef FE_PERF_CNT_EN
    chk("perf_fetch", perf_fetch, 32'd10);
    chk("perf_redir", perf_redir, 32'd2);
    chk("perf_taken", perf_taken, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
